// File: rtl/bsram_arb_pkg.sv
// -----------------------------------------------------------------------------
// bsram_arb_pkg
// Shared definitions for the two-port block-RAM arbiter:
//   AW_DEF / DW_DEF : default RAM address and data widths
//   state_e         : arbiter operating state (INIT clears the RAM, RUN serves)
//   req_t           : one requester's access (default-width view)
// -----------------------------------------------------------------------------
package bsram_arb_pkg;

  localparam int AW_DEF = 10;
  localparam int DW_DEF = 36;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant. The grant is combinational; every grant is a
// transfer, so the last-grant register moves on every grant. On a tie the
// port that was not granted last wins. last_grant resets to 1 so port 0 wins
// the first tie.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   en_i                  : arbitration allowed this cycle
//   valid0_i / valid1_i   : requester valids
//   grant0_o / grant1_o   : one-hot (or zero) grant
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic valid0_i,
  input  logic valid1_i,
  output logic grant0_o,
  output logic grant1_o
);

  logic last_q, last_d;
  logic g0_s, g1_s;

  // Grant selection and last-grant next state
  always_comb begin
    g0_s   = 1'b0;
    g1_s   = 1'b0;
    last_d = last_q;
    if (en_i) begin
      if (valid0_i && valid1_i) begin
        if (last_q) begin
          g0_s = 1'b1;
        end else begin
          g1_s = 1'b1;
        end
      end else if (valid0_i) begin
        g0_s = 1'b1;
      end else if (valid1_i) begin
        g1_s = 1'b1;
      end else begin
        g0_s = 1'b0;
      end
    end else begin
      g0_s = 1'b0;
    end
    if (g0_s) begin
      last_d = 1'b0;
    end else if (g1_s) begin
      last_d = 1'b1;
    end else begin
      last_d = last_q;
    end
  end

  // Last-grant register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  assign grant0_o = g0_s;
  assign grant1_o = g1_s;

endmodule

// File: rtl/bsram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bsram_port_arbiter
// Shares one single-port block RAM (1-cycle registered read) between two
// requesters with round-robin arbitration and per-port read responses.
// Optional build macro BSRAM_ARB_INIT_CLEAR_EN: after reset the block first
// writes zero to every RAM address, holding requesters off until done.
// Ports:
//   CLK, RESET                 : clock, synchronous active-high reset
//   reqN_valid/ready/we/addr/wdata : requester N access handshake
//   rspN_valid/rdata           : read response to requester N
//   ram_ad/di/wre/ce, ram_do   : RAM macro interface
//   init_done                  : arbiter accepting requests
// -----------------------------------------------------------------------------
module bsram_port_arbiter
  import bsram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic          req0_we,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_wdata,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic          req1_we,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_wdata,
  output logic          rsp0_valid,
  output logic [DW-1:0] rsp0_rdata,
  output logic          rsp1_valid,
  output logic [DW-1:0] rsp1_rdata,
  output logic [AW-1:0] ram_ad,
  output logic [DW-1:0] ram_di,
  output logic          ram_wre,
  output logic          ram_ce,
  input  logic [DW-1:0] ram_do,
  output logic          init_done
);

  state_e state_q, state_d;
  logic   init_done_q, init_done_d;
  logic   rsp0_valid_q, rsp0_valid_d;
  logic   rsp1_valid_q, rsp1_valid_d;
  logic   arb_en_s, gnt0_s, gnt1_s, clr_s;

`ifdef BSRAM_ARB_INIT_CLEAR_EN
  logic [AW-1:0] cnt_q, cnt_d;
  // started_q keeps the cycle right after reset idle before clearing begins
  logic          started_q;
  assign clr_s = !RESET && (state_q == ST_INIT) && started_q;
`else
  assign clr_s = 1'b0;
`endif

  // Reset overrides everything combinationally, including grants
  assign arb_en_s = !RESET && init_done_q && (state_q == ST_RUN);

  rr_arb2 u_rr_arb2 (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .en_i     (arb_en_s),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .grant0_o (gnt0_s),
    .grant1_o (gnt1_s)
  );

  assign req0_ready = gnt0_s;
  assign req1_ready = gnt1_s;

  // RAM command: clear sweep, else the granted port, else idle
  always_comb begin
    ram_ad  = '0;
    ram_di  = '0;
    ram_wre = 1'b0;
    ram_ce  = 1'b0;
    if (clr_s) begin
`ifdef BSRAM_ARB_INIT_CLEAR_EN
      ram_ad  = cnt_q;
`endif
      ram_wre = 1'b1;
      ram_ce  = 1'b1;
    end else if (gnt0_s) begin
      ram_ad  = req0_addr;
      ram_di  = req0_wdata;
      ram_wre = req0_we;
      ram_ce  = 1'b1;
    end else if (gnt1_s) begin
      ram_ad  = req1_addr;
      ram_di  = req1_wdata;
      ram_wre = req1_we;
      ram_ce  = 1'b1;
    end else begin
      ram_ce  = 1'b0;
    end
  end

  // Next state: init sweep progress and read-response tags
  always_comb begin
    state_d      = state_q;
    init_done_d  = init_done_q;
    rsp0_valid_d = gnt0_s && !req0_we;
    rsp1_valid_d = gnt1_s && !req1_we;
`ifdef BSRAM_ARB_INIT_CLEAR_EN
    cnt_d = cnt_q;
    if (clr_s) begin
      cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
      if (cnt_q == {AW{1'b1}}) begin
        state_d     = ST_RUN;
        init_done_d = 1'b1;
      end else begin
        state_d     = ST_INIT;
      end
    end else begin
      cnt_d = cnt_q;
    end
`else
    state_d     = ST_RUN;
    init_done_d = 1'b1;
`endif
  end

  // State registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
`ifdef BSRAM_ARB_INIT_CLEAR_EN
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      started_q <= 1'b0;
`else
      state_q   <= ST_RUN;
`endif
      init_done_q  <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
`ifdef BSRAM_ARB_INIT_CLEAR_EN
      cnt_q     <= cnt_d;
      started_q <= 1'b1;
`endif
      state_q      <= state_d;
      init_done_q  <= init_done_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  // A response pending across a reset edge is dropped immediately
  assign rsp0_valid = rsp0_valid_q && !RESET;
  assign rsp1_valid = rsp1_valid_q && !RESET;
  assign rsp0_rdata = ram_do;
  assign rsp1_rdata = ram_do;
  assign init_done  = init_done_q;

endmodule

// File: tb/tb_bsram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bsram_port_arbiter
// Self-checking bench for bsram_port_arbiter with a behavioural RAM and a
// reference model (shadow memory, last-grant bit, cycles-since-reset count).
// Honours BSRAM_ARB_INIT_CLEAR_EN if defined for the build.
// -----------------------------------------------------------------------------
module tb_bsram_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 36;
`ifdef BSRAM_ARB_INIT_CLEAR_EN
  localparam int INIT_LAT = 1025;
`else
  localparam int INIT_LAT = 1;
`endif

  logic          CLK = 1'b0;
  logic          RESET;
  logic          req0_valid, req1_valid, req0_we, req1_we;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_wdata, req1_wdata;
  logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [DW-1:0] rsp0_rdata, rsp1_rdata;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_di;
  logic          ram_wre, ram_ce, init_done;
  logic [DW-1:0] ram_do_r = '0;

  int n_cmp = 0;
  int n_err = 0;

  bsram_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RESET(RESET),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .ram_ad(ram_ad), .ram_di(ram_di), .ram_wre(ram_wre), .ram_ce(ram_ce),
    .ram_do(ram_do_r), .init_done(init_done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] init_word(int a);
    logic [DW-1:0] v;
    v = 36'(a);
    return (v * 36'd40503) ^ 36'hA_5A5A_5A5A;
  endfunction

  // Contents of an address never written by a requester since reset
  function automatic logic [DW-1:0] fresh_word(int a);
`ifdef BSRAM_ARB_INIT_CLEAR_EN
    return 36'h0 & init_word(a);
`else
    return init_word(a);
`endif
  endfunction

  // Behavioural single-port RAM, registered read, DO held on writes
  logic [DW-1:0] ram_mem [1024];
  logic          ram_init_q = 1'b0;
  always @(posedge CLK) begin
    if (!ram_init_q) begin
      for (int a = 0; a < 1024; a++) ram_mem[a] <= init_word(a);
      ram_init_q <= 1'b1;
    end else if (ram_ce) begin
      if (ram_wre) ram_mem[ram_ad] <= ram_di;
      else         ram_do_r <= ram_mem[ram_ad];
    end
  end

  // Reference model
  logic [DW-1:0] shadow [1024];
  logic          sh_init_q = 1'b0;
  int            m_since = 0;
  logic          m_last = 1'b1;
  logic          m_pend0 = 1'b0, m_pend1 = 1'b0;
  logic [DW-1:0] m_exp0 = '0, m_exp1 = '0;
  logic          exp_g0, exp_g1;

  // Expected grant: a lone requester wins; a tie goes to the port not served last
  always_comb begin
    exp_g0 = 1'b0;
    exp_g1 = 1'b0;
    if (!RESET && m_since >= INIT_LAT) begin
      if (req0_valid && req1_valid) begin
        exp_g0 = m_last;
        exp_g1 = !m_last;
      end else begin
        exp_g0 = req0_valid;
        exp_g1 = req1_valid;
      end
    end
  end

  always @(posedge CLK) begin
    if (!sh_init_q) begin
      for (int a = 0; a < 1024; a++) shadow[a] <= init_word(a);
      sh_init_q <= 1'b1;
    end
    if (RESET) begin
      m_since <= 0;
      m_last  <= 1'b1;
      m_pend0 <= 1'b0;
      m_pend1 <= 1'b0;
    end else begin
      if (m_since < 5000) m_since <= m_since + 1;
`ifdef BSRAM_ARB_INIT_CLEAR_EN
      if (m_since >= 1 && m_since <= 1024) shadow[m_since-1] <= '0;
`endif
      m_pend0 <= exp_g0 && !req0_we;
      m_pend1 <= exp_g1 && !req1_we;
      if (exp_g0) begin
        m_last <= 1'b0;
        if (req0_we) shadow[req0_addr] <= req0_wdata;
        else         m_exp0 <= shadow[req0_addr];
      end
      if (exp_g1) begin
        m_last <= 1'b1;
        if (req1_we) shadow[req1_addr] <= req1_wdata;
        else         m_exp1 <= shadow[req1_addr];
      end
    end
  end

  task automatic advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0; req0_we = 1'b0; req1_we = 1'b0;
    req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
  endtask

  // Bounded wait for init_done, then step into the first RUN cycle
  task automatic wait_run();
    bit seen = 1'b0;
    for (int i = 0; i < 1100 && !seen; i++) begin
      @(negedge CLK);
      if (init_done === 1'b1) seen = 1'b1;
      advance();
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL wait_run: init_done got %b want 1 within 1100 cycles", init_done); end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_we = 1'b1; req1_we = 1'b1;
    req0_addr = 10'd3; req1_addr = 10'd4; req0_wdata = 36'h1; req1_wdata = 36'h2;
    for (int c = 0; c < 3; c++) begin
      // c = 0,1 : reset cycles; c = 2 : first cycle after RESET deasserts
      if (c == 2) RESET = 1'b0;
      @(negedge CLK);
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b00) begin n_err++; $display("FAIL reset_ready c%0d: got %b want 00", c, {req0_ready, req1_ready}); end
      n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid c%0d: got %b want 00", c, {rsp0_valid, rsp1_valid}); end
      n_cmp++; if ({ram_ce, ram_wre} !== 2'b00) begin n_err++; $display("FAIL reset_ram_ce_wre c%0d: got %b want 00", c, {ram_ce, ram_wre}); end
      n_cmp++; if (init_done !== 1'b0) begin n_err++; $display("FAIL reset_init_done c%0d: got %b want 0", c, init_done); end
      n_cmp++; if (rsp0_rdata !== ram_do_r) begin n_err++; $display("FAIL reset_rdata c%0d: got %h want %h", c, rsp0_rdata, ram_do_r); end
      advance();
    end
`ifdef BSRAM_ARB_INIT_CLEAR_EN
    for (int i = 0; i < 1024; i++) begin
      @(negedge CLK);
      n_cmp++;
      if (ram_ce !== 1'b1 || ram_wre !== 1'b1 || ram_ad !== 10'(i) || ram_di !== 36'h0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0 || init_done !== 1'b0) begin
        n_err++;
        $display("FAIL init_clear %0d: got ce=%b wre=%b ad=%0d di=%h rdy=%b%b done=%b want 1 1 %0d 0 00 0",
                 i, ram_ce, ram_wre, ram_ad, ram_di, req0_ready, req1_ready, init_done, i);
      end
      advance();
    end
`endif
    // First RUN cycle: tie, port 0 must win; port 0 reads the top address
    req0_we = 1'b0; req1_we = 1'b0; req0_addr = 10'd1023; req1_addr = 10'd7;
    @(negedge CLK);
    n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL first_run_init_done: got %b want 1", init_done); end
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL first_tie_grant: got %b want 10", {req0_ready, req1_ready}); end
    n_cmp++; if (ram_ad !== 10'd1023 || ram_wre !== 1'b0) begin n_err++; $display("FAIL first_read_cmd: got ad=%0d wre=%b want 1023 0", ram_ad, ram_wre); end
    advance();
    // Port 1 alone for three cycles: three consecutive port 1 grants
    req0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req1_addr = 10'(7 + i);
      @(negedge CLK);
      n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin n_err++; $display("FAIL solo1_grant %0d: got %b want 01", i, {req0_ready, req1_ready}); end
      n_cmp++; if ({rsp0_valid, rsp1_valid} !== ((i == 0) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL solo1_rsp %0d: got %b want %b", i, {rsp0_valid, rsp1_valid}, (i == 0) ? 2'b10 : 2'b01); end
      if (i == 0) begin
        n_cmp++; if (rsp0_rdata !== fresh_word(1023)) begin n_err++; $display("FAIL rd1023_data: got %h want %h", rsp0_rdata, fresh_word(1023)); end
      end else begin
        n_cmp++; if (rsp1_rdata !== fresh_word(6 + i)) begin n_err++; $display("FAIL solo1_data %0d: got %h want %h", i, rsp1_rdata, fresh_word(6 + i)); end
      end
      advance();
    end
    idle_inputs();
    advance();
  endtask

  task automatic test_write_read();
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'd10; req0_wdata = 36'h9_ABCD_1234;
    @(negedge CLK);
    n_cmp++; if (req0_ready !== 1'b1 || ram_wre !== 1'b1 || ram_ad !== 10'd10 || ram_di !== 36'h9_ABCD_1234) begin
      n_err++; $display("FAIL wr_cmd: got rdy=%b wre=%b ad=%0d di=%h want 1 1 10 9abcd1234", req0_ready, ram_wre, ram_ad, ram_di); end
    advance();
    req0_we = 1'b0;
    @(negedge CLK);
    n_cmp++; if (req0_ready !== 1'b1 || ram_wre !== 1'b0 || ram_ce !== 1'b1) begin n_err++; $display("FAIL rd_cmd: got rdy=%b wre=%b ce=%b want 1 0 1", req0_ready, ram_wre, ram_ce); end
    n_cmp++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin n_err++; $display("FAIL wr_no_rsp: got %b want 00", {rsp0_valid, rsp1_valid}); end
    advance();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      n_cmp++; if ({rsp0_valid, rsp1_valid} !== ((i == 0) ? 2'b10 : 2'b00)) begin n_err++; $display("FAIL wr_rd_rsp %0d: got %b want %b", i, {rsp0_valid, rsp1_valid}, (i == 0) ? 2'b10 : 2'b00); end
      if (i == 0) begin
        n_cmp++; if (rsp0_rdata !== 36'h9_ABCD_1234) begin n_err++; $display("FAIL wr_rd_data: got %h want 9abcd1234", rsp0_rdata); end
      end
      n_cmp++; if (ram_ce !== 1'b0) begin n_err++; $display("FAIL idle_ce %0d: got %b want 0", i, ram_ce); end
      advance();
    end
  endtask

  task automatic test_alternate();
    // Preload address 5 from port 0 and address 6 from port 1
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 10'd5; req0_wdata = 36'h1_2345_6789;
    advance();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 10'd6; req1_wdata = 36'hF_EDCB_A987;
    advance();
    req0_valid = 1'b1; req0_we = 1'b0; req1_we = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 8) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      @(negedge CLK);
      if (i < 8) begin
        n_cmp++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL alt_grant %0d: got %b want %b", i, {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01); end
      end
      if (i >= 1) begin
        n_cmp++; if ({rsp0_valid, rsp1_valid} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL alt_rsp %0d: got %b want %b", i, {rsp0_valid, rsp1_valid}, (i % 2 == 1) ? 2'b10 : 2'b01); end
        n_cmp++; if (ram_do_r !== ((i % 2 == 1) ? 36'h1_2345_6789 : 36'hF_EDCB_A987) ||
                     ((i % 2 == 1) ? rsp0_rdata : rsp1_rdata) !== ((i % 2 == 1) ? 36'h1_2345_6789 : 36'hF_EDCB_A987)) begin
          n_err++; $display("FAIL alt_data %0d: got %h want %h", i, (i % 2 == 1) ? rsp0_rdata : rsp1_rdata, (i % 2 == 1) ? 36'h1_2345_6789 : 36'hF_EDCB_A987); end
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req0_valid = 1'($urandom_range(0, 1)); req1_valid = 1'($urandom_range(0, 1));
      req0_we = 1'($urandom_range(0, 1));    req1_we = 1'($urandom_range(0, 1));
      req0_addr = 10'($urandom_range(0, 15)); req1_addr = 10'($urandom_range(0, 15));
      req0_wdata = {4'($urandom), 32'($urandom)}; req1_wdata = {4'($urandom), 32'($urandom)};
      @(negedge CLK);
      n_cmp++; if ({req0_ready, req1_ready} !== {exp_g0, exp_g1}) begin n_err++; $display("FAIL rnd_grant %0d: got %b want %b", i, {req0_ready, req1_ready}, {exp_g0, exp_g1}); end
      n_cmp++; if ({rsp0_valid, rsp1_valid} !== {m_pend0, m_pend1}) begin n_err++; $display("FAIL rnd_rsp_valid %0d: got %b want %b", i, {rsp0_valid, rsp1_valid}, {m_pend0, m_pend1}); end
      if (m_pend0) begin
        n_cmp++; if (rsp0_rdata !== m_exp0) begin n_err++; $display("FAIL rnd_rdata0 %0d: got %h want %h", i, rsp0_rdata, m_exp0); end
      end
      if (m_pend1) begin
        n_cmp++; if (rsp1_rdata !== m_exp1) begin n_err++; $display("FAIL rnd_rdata1 %0d: got %h want %h", i, rsp1_rdata, m_exp1); end
      end
      n_cmp++; if (ram_ce !== (exp_g0 | exp_g1)) begin n_err++; $display("FAIL rnd_ce %0d: got %b want %b", i, ram_ce, exp_g0 | exp_g1); end
      if (exp_g0 | exp_g1) begin
        n_cmp++;
        if (ram_ad !== (exp_g0 ? req0_addr : req1_addr) || ram_wre !== (exp_g0 ? req0_we : req1_we) ||
            (ram_wre && ram_di !== (exp_g0 ? req0_wdata : req1_wdata))) begin
          n_err++; $display("FAIL rnd_cmd %0d: got ad=%0d wre=%b di=%h want ad=%0d wre=%b di=%h", i, ram_ad, ram_wre, ram_di,
                            exp_g0 ? req0_addr : req1_addr, exp_g0 ? req0_we : req1_we, exp_g0 ? req0_wdata : req1_wdata);
        end
      end
      advance();
    end
    idle_inputs();
    advance();
  endtask

  task automatic test_reset_mid();
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 10'd3;
    @(negedge CLK);
    n_cmp++; if (req1_ready !== 1'b1) begin n_err++; $display("FAIL mid_rd_grant: got %b want 1", req1_ready); end
    advance();
    idle_inputs();
    RESET = 1'b1;
    @(negedge CLK);
    n_cmp++; if (rsp1_valid !== 1'b0) begin n_err++; $display("FAIL mid_rsp_dropped: got %b want 0", rsp1_valid); end
    advance();
    RESET = 1'b0;
    @(negedge CLK);
    n_cmp++; if ({rsp1_valid, init_done, ram_ce} !== 3'b000) begin n_err++; $display("FAIL mid_after: got rsp1/done/ce=%b want 000", {rsp1_valid, init_done, ram_ce}); end
    advance();
    @(negedge CLK);
`ifdef BSRAM_ARB_INIT_CLEAR_EN
    n_cmp++; if (ram_ad !== 10'd0 || ram_wre !== 1'b1) begin n_err++; $display("FAIL mid_clear_restart: got ad=%0d wre=%b want 0 1", ram_ad, ram_wre); end
    advance();
    wait_run();
`else
    n_cmp++; if (init_done !== 1'b1) begin n_err++; $display("FAIL mid_init_done: got %b want 1", init_done); end
    advance();
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    idle_inputs();
    test_reset();
    test_write_read();
    test_alternate();
    test_random();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bsram_port_arbiter.md
BSRAM_PORT_ARBITER -- requirements
Module: bsram_port_arbiter

Interface
REQ-001 SHALL have parameter AW, default 10, the RAM address width.
REQ-002 SHALL have parameter DW, default 36, the RAM data width.
REQ-003 SHALL have one clock, CLK, and a synchronous, active-high reset, RESET.
REQ-004 Ports (name  direction  width  meaning):
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- req0_valid / req1_valid  in  1  requester n has an access
- req0_ready / req1_ready  out  1  requester n access accepted this cycle
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  AW  access address
- req0_wdata / req1_wdata  in  DW  write data
- rsp0_valid / rsp1_valid  out  1  read data valid for requester n
- rsp0_rdata / rsp1_rdata  out  DW  read data
- ram_ad  out  AW  RAM address
- ram_di  out  DW  RAM write data
- ram_wre  out  1  RAM write enable
- ram_ce  out  1  RAM clock enable
- ram_do  in  DW  RAM registered output, valid 1 cycle after a read
- init_done  out  1  arbiter accepting requests

Function
REQ-005 SHALL share one single-port RAM between two requesters, with 1 read-latency cycle; RAM DO holds its value on write cycles.
REQ-006 SHALL have two states, INIT and RUN; in INIT, req0_ready and req1_ready are 0.
REQ-007 In RUN, an access transfers when reqN_valid and reqN_ready are both 1; at most one transfer occurs per cycle.
REQ-008 Grant (combinational):
- only one valid: grant that port
- both valid: grant the port not equal to last_grant
- none valid: no grant, ram_ce = 0
REQ-009 SHALL update last_grant only on a transfer; reset value is 1, so port 0 wins the first tie.
REQ-010 On a transfer, SHALL drive ram_ad, ram_di and ram_wre from the granted port in the same cycle, with ram_ce = 1.
REQ-011 On a read transfer at edge k, SHALL assert rspN_valid for exactly the cycle after edge k, with rspN_rdata = ram_do.
- writes produce no response
- rsp of the other port stays 0
REQ-012 reqN_valid SHALL NOT depend on reqN_ready; the arbiter makes no other ordering guarantee.
REQ-013 Back-to-back reads on alternate ports SHALL yield one response per cycle, each routed to the port that issued it.
REQ-014 A write followed by a read to the same address SHALL return the written data (single-port RAM, no hazard).
REQ-015 When both ports are continuously valid, grants SHALL alternate 0,1,0,1,...

Reset
REQ-016 RESET has priority over all other inputs; the following values apply in the reset cycle and the cycle after it:
- req*_ready = 0, rsp*_valid = 0, rsp*_rdata = ram_do
- ram_wre = 0, ram_ce = 0
- init_done = 0
- last_grant = 1
- init counter = 0
REQ-017 RESET asserted mid-operation SHALL drop any pending response, with no rsp*_valid in the following cycle, and SHALL restart from the reset state.

Configuration
REQ-018 Macro BSRAM_ARB_INIT_CLEAR_EN.
- Defined: after reset, the state is INIT and the block writes 0 to addresses 0..2^AW-1, one address per cycle (ram_ce = 1, ram_wre = 1, ram_di = 0).
- Defined: after address 2^AW-1, the counter wraps, the state becomes RUN and init_done = 1 on that edge, so the first request is accepted 2^AW+1 cycles after RESET deasserts.
- Defined: requests presented during INIT are held off (ready = 0), not dropped.
- Undefined: the state resets to RUN, no clear occurs, and init_done becomes 1 at the first edge with RESET = 0.

Structure
REQ-019 SHALL place in package bsram_arb_pkg:
- AW and DW defaults
- state enum (INIT, RUN)
- request struct (we, addr, wdata)
REQ-020 SHALL instantiate one sub-module, rr_arb2: a 2-way round-robin grant with last_grant register.

Verification
REQ-021 Reset with macro defined -> ram_wre = 1 for 1024 consecutive cycles, addresses 0..1023, data 0; init_done = 1 at cycle 1024.
REQ-022 Port 0 writes 36'h9_ABCD_1234 to address 10, then reads address 10 -> rsp0_valid for 1 cycle with rdata 36'h9_ABCD_1234; rsp1_valid stays 0.
REQ-023 Both ports continuously valid reading addresses 5 and 6 -> grants 0,1,0,1; responses alternate rsp0 (addr 5 data) then rsp1 (addr 6 data) each cycle.
REQ-024 Both ports valid on the first RUN cycle -> port 0 granted first; if port 1 is then valid alone for 3 cycles -> 3 consecutive port 1 grants.
REQ-025 RESET asserted in the cycle after a port 1 read transfer -> rsp1_valid stays 0; with macro defined, init restarts at address 0.
REQ-026 Macro undefined -> init_done = 1 one cycle after RESET deasserts, and a port 0 read of address 1023 is accepted immediately.
